car_physics: RTL and testbench

Game-state producer for the two-player split-screen racer: turns the {Up, Down, Left, Right} buttons of both players into world positions and headings for the VGA renderer. Once per game tick it runs a fixed-length update sequence:
- steer and accelerate each car,
- compute its candidate position,
- check the candidate against the track map through a dedicated map-ROM read port,
- commit or reject the move.

The renderer reads the outputs, and they change atomically once per tick.

---
 rtl/racer_pkg.sv | 80 ++++++++
 rtl/car_step.sv | 65 ++++++
 rtl/car_physics.sv | 223 ++++++++++++++++++++++
 tb/tb_car_physics.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/racer_pkg.sv
// Shared types and constants for the split-screen racer game-state logic.
package racer_pkg;

  // Bit positions inside a {Up, Down, Left, Right} button nibble
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  // Map pixel value that cars may not drive onto
  localparam logic [11:0] DEF_GRASS_COLOR = 12'h0A0;

  // Start positions in whole map pixels
  localparam int DEF_P1_X0 = 150;
  localparam int DEF_P1_Y0 = 200;
  localparam int DEF_P2_X0 = 170;
  localparam int DEF_P2_Y0 = 200;

  // Position in Q10.2: ten integer pixel bits, two fraction bits
  typedef logic [11:0] pos_t;

  // One game tick walks this sequence once, P1 first, then P2
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CALC1,
    ST_ADDR1,
    ST_WAIT1,
    ST_CHECK1,
    ST_CALC2,
    ST_ADDR2,
    ST_WAIT2,
    ST_CHECK2,
    ST_PUBLISH
  } state_t;

  // Q2 unit-vector x component for heading h (0 = north, clockwise)
  function automatic logic signed [3:0] dir_x(input logic [3:0] h);
    case (h)
      4'd0:    dir_x =  4'sd0;
      4'd1:    dir_x =  4'sd2;
      4'd2:    dir_x =  4'sd3;
      4'd3:    dir_x =  4'sd4;
      4'd4:    dir_x =  4'sd4;
      4'd5:    dir_x =  4'sd4;
      4'd6:    dir_x =  4'sd3;
      4'd7:    dir_x =  4'sd2;
      4'd8:    dir_x =  4'sd0;
      4'd9:    dir_x = -4'sd2;
      4'd10:   dir_x = -4'sd3;
      4'd11:   dir_x = -4'sd4;
      4'd12:   dir_x = -4'sd4;
      4'd13:   dir_x = -4'sd4;
      4'd14:   dir_x = -4'sd3;
      default: dir_x = -4'sd2;
    endcase
  endfunction

  // Q2 unit-vector y component for heading h (screen y grows southward)
  function automatic logic signed [3:0] dir_y(input logic [3:0] h);
    case (h)
      4'd0:    dir_y = -4'sd4;
      4'd1:    dir_y = -4'sd4;
      4'd2:    dir_y = -4'sd3;
      4'd3:    dir_y = -4'sd2;
      4'd4:    dir_y =  4'sd0;
      4'd5:    dir_y =  4'sd2;
      4'd6:    dir_y =  4'sd3;
      4'd7:    dir_y =  4'sd4;
      4'd8:    dir_y =  4'sd4;
      4'd9:    dir_y =  4'sd4;
      4'd10:   dir_y =  4'sd3;
      4'd11:   dir_y =  4'sd2;
      4'd12:   dir_y =  4'sd0;
      4'd13:   dir_y = -4'sd2;
      4'd14:   dir_y = -4'sd3;
      default: dir_y = -4'sd4;
    endcase
  endfunction

endpackage

// File: rtl/car_step.sv
// Combinational single-car update: steering, throttle and candidate move.
module car_step
  import racer_pkg::*;
#(
  parameter int MAX_FWD = 4,
  parameter int MAX_REV = 2,
  parameter int MAP_W   = 320,
  parameter int MAP_H   = 240
) (
  input  logic [3:0]        btn,
  input  logic [3:0]        heading,
  input  logic signed [3:0] speed,
  input  pos_t              pos_x,
  input  pos_t              pos_y,
  output logic [3:0]        heading_new,
  output logic signed [3:0] speed_new,
  output pos_t              cand_x,
  output pos_t              cand_y,
  output logic              oob
);

  localparam logic signed [3:0]  SPD_MAX = 4'(MAX_FWD);
  localparam logic signed [3:0]  SPD_MIN = 4'(-MAX_REV);
  localparam logic signed [12:0] X_LIM   = 13'(MAP_W * 4);
  localparam logic signed [12:0] Y_LIM   = 13'(MAP_H * 4);

  logic              up, dn, lt, rt;
  logic signed [7:0]  dx, dy;
  logic signed [12:0] sx, sy;

  // Heading and speed follow the buttons; the move uses the updated values
  always_comb begin
    up = btn[BTN_UP];
    dn = btn[BTN_DOWN];
    lt = btn[BTN_LEFT];
    rt = btn[BTN_RIGHT];

    heading_new = heading;
    if (lt && !rt)      heading_new = heading - 4'd1;
    else if (rt && !lt) heading_new = heading + 4'd1;

    if (up && !dn)
      speed_new = (speed >= SPD_MAX) ? SPD_MAX : speed + 4'sd1;
    else if (dn && !up)
      speed_new = (speed <= SPD_MIN) ? SPD_MIN : speed - 4'sd1;
    else if (speed > 4'sd0)
      speed_new = speed - 4'sd1;
    else if (speed < 4'sd0)
      speed_new = speed + 4'sd1;
    else
      speed_new = 4'sd0;

    dx = 8'(speed_new) * 8'(dir_x(heading_new));
    dy = 8'(speed_new) * 8'(dir_y(heading_new));

    // 13-bit signed so that a step off the top/left edge shows up as negative
    sx = $signed({1'b0, pos_x}) + 13'(dx);
    sy = $signed({1'b0, pos_y}) + 13'(dy);

    oob    = sx[12] || sy[12] || (sx >= X_LIM) || (sy >= Y_LIM);
    cand_x = sx[11:0];
    cand_y = sy[11:0];
  end

endmodule

// File: rtl/car_physics.sv
// Two-car game-state producer: one fixed-length update sequence per game tick,
// map collision through a shared ROM port, atomic publish to the renderer.
module car_physics
  import racer_pkg::*;
#(
  parameter int          TICK_DIV      = 1666666,
  parameter int          MAP_BASE_ADDR = 90001,
  parameter int          MAP_W         = 320,
  parameter int          MAP_H         = 240,
  parameter logic [11:0] GRASS_COLOR   = DEF_GRASS_COLOR,
  parameter int          MAX_FWD       = 4,
  parameter int          MAX_REV       = 2,
  parameter int          P1_X0         = DEF_P1_X0,
  parameter int          P1_Y0         = DEF_P1_Y0,
  parameter int          P2_X0         = DEF_P2_X0,
  parameter int          P2_Y0         = DEF_P2_Y0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  p1_btn,
  input  logic [3:0]  p2_btn,
  output logic [17:0] map_addr,
  input  logic [11:0] map_data,
  output logic [9:0]  p1_world_x,
  output logic [9:0]  p1_world_y,
  output logic [3:0]  p1_degree,
  output logic [9:0]  p2_world_x,
  output logic [9:0]  p2_world_y,
  output logic [3:0]  p2_degree
);

  localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              tick;
  logic [3:0]        p1_s1_q, p1_s2_q, p2_s1_q, p2_s2_q;

  // Per-car live state (index 0 = P1, 1 = P2)
  pos_t              x_q [2], x_d [2];
  pos_t              y_q [2], y_d [2];
  logic [3:0]        hd_q [2], hd_d [2];
  logic signed [3:0] spd_q [2], spd_d [2];

  // Published outputs
  logic [9:0]        ox_q [2], ox_d [2];
  logic [9:0]        oy_q [2], oy_d [2];
  logic [3:0]        od_q [2], od_d [2];

  // Scratch results carried from CALC to CHECK
  pos_t              cx_q, cx_d, cy_q, cy_d;
  logic [3:0]        nhd_q, nhd_d;
  logic signed [3:0] nspd_q, nspd_d;
  logic              oob_q, oob_d;
  logic [17:0]       addr_q, addr_d;

  logic              car_sel;
  logic [3:0]        step_btn;
  logic [3:0]        step_hd;
  logic signed [3:0] step_spd;
  pos_t              step_cx, step_cy;
  logic              step_oob;
  logic              reject;

  // Word address of an in-bounds candidate; y*320 is built from two shifts
  function automatic logic [17:0] map_word(input pos_t qx, input pos_t qy);
    logic [9:0] px, py;
    px = qx[11:2];
    py = qy[11:2];
    map_word = 18'(MAP_BASE_ADDR) + {py, 8'b0} + {2'b0, py, 6'b0} + {8'b0, px};
  endfunction

  assign car_sel  = (state_q == ST_CALC2);
  assign step_btn = car_sel ? p2_s2_q : p1_s2_q;

  car_step #(
    .MAX_FWD (MAX_FWD),
    .MAX_REV (MAX_REV),
    .MAP_W   (MAP_W),
    .MAP_H   (MAP_H)
  ) u_step (
    .btn         (step_btn),
    .heading     (hd_q[car_sel]),
    .speed       (spd_q[car_sel]),
    .pos_x       (x_q[car_sel]),
    .pos_y       (y_q[car_sel]),
    .heading_new (step_hd),
    .speed_new   (step_spd),
    .cand_x      (step_cx),
    .cand_y      (step_cy),
    .oob         (step_oob)
  );

  assign tick   = (cnt_q == CNT_LAST);
  assign reject = oob_q || (map_data == GRASS_COLOR);

  // Sequencer: tick/pending start, per-car calc/lookup/commit, final publish
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    pend_d  = pend_q;
    x_d     = x_q;
    y_d     = y_q;
    hd_d    = hd_q;
    spd_d   = spd_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    od_d    = od_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    nhd_d   = nhd_q;
    nspd_d  = nspd_q;
    oob_d   = oob_q;
    addr_d  = addr_q;

    if (state_q != ST_IDLE && tick) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tick || pend_q) begin
          state_d = ST_CALC1;
          pend_d  = 1'b0;
        end
      end
      ST_CALC1, ST_CALC2: begin
        state_d = (state_q == ST_CALC1) ? ST_ADDR1 : ST_ADDR2;
        cx_d    = step_cx;
        cy_d    = step_cy;
        nhd_d   = step_hd;
        nspd_d  = step_spd;
        oob_d   = step_oob;
        addr_d  = step_oob ? 18'd0 : map_word(step_cx, step_cy);
      end
      ST_ADDR1:  state_d = ST_WAIT1;
      ST_WAIT1:  state_d = ST_CHECK1;
      ST_ADDR2:  state_d = ST_WAIT2;
      ST_WAIT2:  state_d = ST_CHECK2;
      ST_CHECK1, ST_CHECK2: begin
        state_d = (state_q == ST_CHECK1) ? ST_CALC2 : ST_PUBLISH;
        // Heading always follows the stick; a rejected move also kills speed
        hd_d[state_q == ST_CHECK2]  = nhd_q;
        spd_d[state_q == ST_CHECK2] = reject ? 4'sd0 : nspd_q;
        if (!reject) begin
          x_d[state_q == ST_CHECK2] = cx_q;
          y_d[state_q == ST_CHECK2] = cy_q;
        end
      end
      ST_PUBLISH: begin
        state_d = ST_IDLE;
        for (int c = 0; c < 2; c++) begin
          ox_d[c] = x_q[c][11:2];
          oy_d[c] = y_q[c][11:2];
          od_d[c] = hd_q[c];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Game state, published outputs and button synchronisers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      p1_s1_q  <= '0;
      p1_s2_q  <= '0;
      p2_s1_q  <= '0;
      p2_s2_q  <= '0;
      x_q[0]   <= 12'(P1_X0 * 4);
      y_q[0]   <= 12'(P1_Y0 * 4);
      x_q[1]   <= 12'(P2_X0 * 4);
      y_q[1]   <= 12'(P2_Y0 * 4);
      hd_q[0]  <= '0;
      hd_q[1]  <= '0;
      spd_q[0] <= '0;
      spd_q[1] <= '0;
      ox_q[0]  <= 10'(P1_X0);
      oy_q[0]  <= 10'(P1_Y0);
      ox_q[1]  <= 10'(P2_X0);
      oy_q[1]  <= 10'(P2_Y0);
      od_q[0]  <= '0;
      od_q[1]  <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      p1_s1_q  <= p1_btn;
      p1_s2_q  <= p1_s1_q;
      p2_s1_q  <= p2_btn;
      p2_s2_q  <= p2_s1_q;
      x_q      <= x_d;
      y_q      <= y_d;
      hd_q     <= hd_d;
      spd_q    <= spd_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      od_q     <= od_d;
      addr_q   <= addr_d;
    end
  end

  // CALC-to-CHECK scratch; always written before it is read in a sequence
  always_ff @(posedge clk) begin
    cx_q   <= cx_d;
    cy_q   <= cy_d;
    nhd_q  <= nhd_d;
    nspd_q <= nspd_d;
    oob_q  <= oob_d;
  end

  assign map_addr   = addr_q;
  assign p1_world_x = ox_q[0];
  assign p1_world_y = oy_q[0];
  assign p1_degree  = od_q[0];
  assign p2_world_x = ox_q[1];
  assign p2_world_y = oy_q[1];
  assign p2_degree  = od_q[1];

endmodule

// File: tb/tb_car_physics.sv
// Directed bench for car_physics: a 20-cycle-tick instance for the main
// scenarios and a 4-cycle-tick instance for back-to-back tick collapsing.
module tb_car_physics;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  p1_btn = '0, p2_btn = '0, f_p1_btn = '0, f_p2_btn = '0;
  logic [17:0] map_addr, f_map_addr;
  logic [11:0] map_data = '0, f_map_data = '0;
  logic [9:0]  p1_world_x, p1_world_y, p2_world_x, p2_world_y;
  logic [3:0]  p1_degree, p2_degree;
  logic [9:0]  f_p1_world_x, f_p1_world_y, f_p2_world_x, f_p2_world_y;
  logic [3:0]  f_p1_degree, f_p2_degree;
  logic        grass_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Pixel (150,199): 90001 + 199*320 + 150
  localparam logic [17:0] GRASS_ADDR = 18'd153831;
  localparam logic [3:0]  B_UP = 4'b1000, B_DN = 4'b0100, B_LT = 4'b0010, B_RT = 4'b0001;

  always #5 clk = ~clk;

  // Synchronous map ROMs: data one cycle after address
  always @(posedge clk) map_data   <= (grass_en && map_addr == GRASS_ADDR) ? 12'h0A0 : 12'h555;
  always @(posedge clk) f_map_data <= 12'h555;

  car_physics #(.TICK_DIV(20)) dut (
    .clk(clk), .rst(rst), .p1_btn(p1_btn), .p2_btn(p2_btn),
    .map_addr(map_addr), .map_data(map_data),
    .p1_world_x(p1_world_x), .p1_world_y(p1_world_y), .p1_degree(p1_degree),
    .p2_world_x(p2_world_x), .p2_world_y(p2_world_y), .p2_degree(p2_degree)
  );

  car_physics #(.TICK_DIV(4)) dut_fast (
    .clk(clk), .rst(rst), .p1_btn(f_p1_btn), .p2_btn(f_p2_btn),
    .map_addr(f_map_addr), .map_data(f_map_data),
    .p1_world_x(f_p1_world_x), .p1_world_y(f_p1_world_y), .p1_degree(f_p1_degree),
    .p2_world_x(f_p2_world_x), .p2_world_y(f_p2_world_y), .p2_degree(f_p2_degree)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the c-th rising edge since reset release
  task automatic goto(input int c);
    if (cyc < c) begin
      while (cyc < c) begin
        @(posedge clk);
        cyc++;
      end
      #1;
    end
  endtask

  initial begin
    int n;
    int chg_cyc [4];
    logic [3:0] chg_val [4];
    logic [3:0] prev;

    // ---- reset state; P1 Up already held for the first tick (T=19)
    p1_btn = B_UP;
    #11;
    check("rst_p1x", p1_world_x, 150);
    check("rst_p1y", p1_world_y, 200);
    check("rst_p1d", p1_degree, 0);
    check("rst_p2x", p2_world_x, 170);
    check("rst_p2y", p2_world_y, 200);
    check("rst_p2d", p2_degree, 0);
    check("rst_addr", map_addr, 0);
    #1 rst = 1'b0;
    cyc = 0;

    // ---- P1 Up from rest: y 800 -> 796 quarter-pixels
    goto(21);  check("a_addr_p1", map_addr, 153831);
    goto(25);  check("a_addr_p2", map_addr, 90001 + 200*320 + 170);
    p1_btn = '0;
    goto(28);  check("a_hold_y", p1_world_y, 200);
    goto(29);  check("a_p1y", p1_world_y, 199);
               check("a_p1x", p1_world_x, 150);
    p1_btn = B_LT;

    // ---- steering: Left 0->15, Left+Right unchanged, Right 15->0
    goto(48);  check("b_hold_deg", p1_degree, 0);
    goto(49);  check("b_left", p1_degree, 15);
    p1_btn = B_LT | B_RT;
    goto(69);  check("b_both", p1_degree, 15);
    p1_btn = B_RT;
    goto(89);  check("b_right", p1_degree, 0);
               check("b_y_coast", p1_world_y, 199);
    p1_btn = B_UP;

    // ---- asynchronous reset in the middle of the T=99 sequence
    goto(104);
    rst = 1'b1;
    #1;
    check("mr_p1y", p1_world_y, 200);
    check("mr_p1x", p1_world_x, 150);
    check("mr_p1d", p1_degree, 0);
    check("mr_p2x", p2_world_x, 170);
    check("mr_addr", map_addr, 0);
    grass_en = 1'b1;
    goto(106);
    #1 rst = 1'b0;
    cyc = 0;
    goto(5);   check("mr_no_publish", p1_world_y, 200);

    // ---- grass at (150,199): Up is rejected, speed cleared
    goto(29);  check("g_p1y", p1_world_y, 200);
               check("g_p1x", p1_world_x, 150);
    goto(30);  grass_en = 1'b0;
    goto(49);  check("g_restart_speed", p1_world_y, 199);
    p1_btn = '0;
    p2_btn = B_LT;

    // ---- P2: turn to 12, drive west to x=0, then step off the edge
    goto(129); check("p2_deg12", p2_degree, 12);
    p2_btn = B_UP;
    goto(1009);
    check("p2_at_edge_x", p2_world_x, 0);
    check("p2_at_edge_y", p2_world_y, 200);
    goto(1021); check("p2_p1addr", map_addr, 153831);
    goto(1025); check("p2_oob_addr", map_addr, 0);
    goto(1029); check("p2_oob_kept", p2_world_x, 0);
    p2_btn = B_DN;
    goto(1049); check("p2_speed_cleared", p2_world_x, 1);

    // ---- fast instance: busy-time ticks collapse into one pending start
    f_p1_btn = B_LT;
    rst = 1'b1;
    goto(1051);
    #1 rst = 1'b0;
    cyc = 0;
    prev = f_p1_degree;
    check("f_rst_deg", f_p1_degree, 0);
    n = 0;
    for (int c = 1; c <= 45; c++) begin
      goto(c);
      if (f_p1_degree !== prev) begin
        if (n < 4) begin
          chg_cyc[n] = c;
          chg_val[n] = f_p1_degree;
        end
        n++;
        prev = f_p1_degree;
      end
    end
    check("f_updates", n, 4);
    for (int i = 0; i < 4 && i < n; i++) begin
      check($sformatf("f_cyc%0d", i), chg_cyc[i], 13 + 10*i);
      check($sformatf("f_deg%0d", i), chg_val[i], 15 - i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
